agc_dither_round: RTL and testbench



---
 rtl/agc_dither_round_if.sv | 38 +++
 rtl/agc_dither_round.sv | 226 ++++++++++++++++++++++
 tb/tb_agc_dither_round.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/agc_dither_round_if.sv
// agc_dither_round_if
//   Sample stream bundle between the AGC scaler and the dithered requantizer.
//   The upstream side (master) drives the wide scaled sample and its valid;
//   the requantizer (slave) returns the narrowed sample, its valid and the
//   clip flag. There is no backpressure in either direction.
//
//   Signals:
//     in_i        NIN-bit signed scaled sample
//     in_valid_i  qualifier for in_i
//     out_o       NOUT-bit signed requantized sample
//     out_valid_o qualifier for out_o and sat_o
//     sat_o       out_o was clipped to the output range
interface agc_dither_round_if #(
  parameter int NIN  = 17,
  parameter int NOUT = 5
);
  logic [NIN-1:0]  in_i;
  logic            in_valid_i;
  logic [NOUT-1:0] out_o;
  logic            out_valid_o;
  logic            sat_o;

  modport master (
    output in_i,
    output in_valid_i,
    input  out_o,
    input  out_valid_o,
    input  sat_o
  );

  modport slave (
    input  in_i,
    input  in_valid_i,
    output out_o,
    output out_valid_o,
    output sat_o
  );
endinterface

// File: rtl/agc_dither_round.sv
// agc_dither_round
//   Dithered requantizer sitting behind the AGC's 3-bit LFSR dither source.
//   Each wide sample gets the three random bits added just below the output
//   LSB, is arithmetic-shifted down to NOUT bits and saturated. A small FSM
//   sequences the LFSR (reset, start pulse, warm-up) and dither is only
//   applied once the LFSR has warmed up; before that samples are truncated
//   toward minus infinity.
//
//   Optional feature macro: AGC_DITHER_SATCNT_EN
//     defined   -> 16-bit sticky saturation counter with clear input
//     undefined -> sat_count_o tied to zero, sat_clr_i ignored
//
//   Ports:
//     clk_i         clock
//     rstn_i        asynchronous active-low reset
//     en_i          level enable for the LFSR sequence and dithering
//     lfsr_rst_o    reset to the LFSR generator (high in IDLE and LRST)
//     lfsr_start_o  one-cycle start pulse to the LFSR generator
//     rnd_i         3 registered random bits from the LFSR
//     bus           sample stream (slave side of agc_dither_round_if)
//     dither_on_o   high while dither is being applied (RUN)
//     sat_clr_i     clears the saturation counter
//     sat_count_o   saturated-sample count
module agc_dither_round #(
  parameter int NIN    = 17,
  parameter int NOUT   = 5,
  parameter int WARMUP = 40
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  output logic                 lfsr_rst_o,
  output logic                 lfsr_start_o,
  input  logic [2:0]           rnd_i,
  agc_dither_round_if.slave    bus,
  output logic                 dither_on_o,
  input  logic                 sat_clr_i,
  output logic [15:0]          sat_count_o
);

  localparam int DROP = NIN - NOUT;
  localparam int SW   = NIN + 1;
  localparam int QW   = SW - DROP;
  localparam logic [7:0] LRST_LAST = 8'd3;
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  typedef enum logic [2:0] {
    IDLE,
    LRST,
    START,
    WARM,
    RUN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lfsr_rst_q, lfsr_rst_d;
  logic       lfsr_start_q, lfsr_start_d;
  logic       dither_on_q, dither_on_d;

  // Sequencer: dropping en_i returns to IDLE from anywhere. The output
  // flops are computed from the next state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LRST;
          cnt_d   = '0;
        end
        LRST: begin
          if (cnt_q == LRST_LAST) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        START: begin
          state_d = WARM;
          cnt_d   = '0;
        end
        WARM: begin
          if (cnt_q == WARM_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    lfsr_rst_d   = (state_d == IDLE) || (state_d == LRST);
    lfsr_start_d = (state_d == START);
    dither_on_d  = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lfsr_rst_q   <= 1'b1;
      lfsr_start_q <= 1'b0;
      dither_on_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_rst_q   <= lfsr_rst_d;
      lfsr_start_q <= lfsr_start_d;
      dither_on_q  <= dither_on_d;
    end
  end

  assign lfsr_rst_o   = lfsr_rst_q;
  assign lfsr_start_o = lfsr_start_q;
  assign dither_on_o  = dither_on_q;

  // Stage 1: add the dither three bits below the output LSB and keep only
  // the part that survives the shift. Dither is chosen by the state seen on
  // the input cycle, so samples in flight keep what they captured here.
  logic [2:0]      dith;
  logic [SW-1:0]   in_ext;
  logic [SW-1:0]   dith_ext;
  logic [SW-1:0]   sum;
  logic [QW-1:0]   sum_hi;
  logic [DROP-1:0] sum_lsb_unused;
  logic [QW-1:0]   s1_q_q, s1_q_d;
  logic            s1_valid_q;

  always_comb begin
    dith                    = (state_q == RUN) ? rnd_i : 3'd0;
    in_ext                  = {bus.in_i[NIN-1], bus.in_i};
    dith_ext                = '0;
    dith_ext[DROP-1 -: 3]   = dith;
    sum                     = in_ext + dith_ext;
    {sum_hi, sum_lsb_unused} = sum;
    s1_q_d                  = bus.in_valid_i ? sum_hi : s1_q_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_q_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_q_q     <= s1_q_d;
      s1_valid_q <= bus.in_valid_i;
    end
  end

  // Stage 2: the shifted value is one bit wider than the output, so it
  // overflows exactly when its top two bits disagree; the sign bit then
  // picks which rail to clip to.
  logic [NOUT-1:0] out_q, out_d;
  logic            sat_q, sat_d;
  logic            out_valid_q;
  logic            ovf;
  logic [NOUT-1:0] clipped;

  always_comb begin
    ovf = s1_q_q[QW-1] ^ s1_q_q[QW-2];
    if (ovf) begin
      clipped = s1_q_q[QW-1] ? {1'b1, {(NOUT-1){1'b0}}} : {1'b0, {(NOUT-1){1'b1}}};
    end else begin
      clipped = s1_q_q[NOUT-1:0];
    end
    out_d = s1_valid_q ? clipped : out_q;
    sat_d = s1_valid_q ? ovf : sat_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= s1_valid_q;
    end
  end

  assign bus.out_o       = out_q;
  assign bus.sat_o       = sat_q;
  assign bus.out_valid_o = out_valid_q;

`ifdef AGC_DITHER_SATCNT_EN
  // Sticky count of clipped samples; a clear wins over a coincident
  // saturated sample so the AGC loop always sees a clean restart.
  logic [15:0] sat_count_q, sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr_i) begin
      sat_count_d = '0;
    end else if (out_valid_q && sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count_o = sat_count_q;
`else
  logic sat_clr_unused;
  assign sat_clr_unused = sat_clr_i;
  assign sat_count_o    = '0;
`endif

endmodule

// File: tb/tb_agc_dither_round.sv
// tb_agc_dither_round
//   Directed bench for agc_dither_round (NIN=17, NOUT=5, WARMUP=40).
//   Stimulus pushes hand-computed expected samples into a scoreboard queue;
//   a negedge monitor pops and compares whenever out_valid_o is high,
//   including the two-cycle latency. Sequencer outputs are checked directly.
module tb_agc_dither_round;

  localparam int NIN    = 17;
  localparam int NOUT   = 5;
  localparam int WARMUP = 40;

`ifdef AGC_DITHER_SATCNT_EN
  localparam int CNT_ONE = 1;
`else
  localparam int CNT_ONE = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        sat_clr = 1'b0;
  logic [2:0]  rnd = 3'd0;
  logic        lfsr_rst;
  logic        lfsr_start;
  logic        dither_on;
  logic [15:0] sat_count;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  agc_dither_round_if #(.NIN(NIN), .NOUT(NOUT)) bus ();

  agc_dither_round #(.NIN(NIN), .NOUT(NOUT), .WARMUP(WARMUP)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .en_i         (en),
    .lfsr_rst_o   (lfsr_rst),
    .lfsr_start_o (lfsr_start),
    .rnd_i        (rnd),
    .bus          (bus),
    .dither_on_o  (dither_on),
    .sat_clr_i    (sat_clr),
    .sat_count_o  (sat_count)
  );

  // Cycle index: 0 is the cycle right after reset release
  int cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [4:0] out;
    logic       sat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Single comparison with a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one sample for one cycle and record its expected result
  task automatic applyStimulus(input logic [16:0] din, input logic [2:0] r,
                               input logic [4:0] eo, input logic es);
    exp_t e;
    bus.in_i       = din;
    bus.in_valid_i = 1'b1;
    rnd            = r;
    e.out = eo;
    e.sat = es;
    e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    rnd            = 3'd0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.out_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got out %0h with empty queue (cycle %0d)", bus.out_o, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("out_o", 32'(bus.out_o), 32'(e.out));
        checkOutput("sat_o", 32'(bus.sat_o), 32'(e.sat));
        checkOutput("latency", 32'(cyc), 32'(e.cyc + 2));
      end
    end
  end

  // Startup sequence of the LFSR control outputs after the first release
  initial begin
    @(posedge rstn);
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      checkOutput("lfsr_rst_o_startup", 32'(lfsr_rst), 32'(cyc <= 4));
      checkOutput("lfsr_start_o_startup", 32'(lfsr_start), 32'(cyc == 5));
      checkOutput("dither_on_o_startup", 32'(dither_on), 32'(cyc >= 6 + WARMUP));
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_i       = '0;
    bus.in_valid_i = 1'b0;

    // Reset values while held in reset
    #12;
    checkOutput("reset_lfsr_rst", 32'(lfsr_rst), 32'd1);
    checkOutput("reset_lfsr_start", 32'(lfsr_start), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("reset_out_o", 32'(bus.out_o), 32'd0);
    checkOutput("reset_sat_o", 32'(bus.sat_o), 32'd0);
    checkOutput("reset_dither_on", 32'(dither_on), 32'd0);
    checkOutput("reset_sat_count", 32'(sat_count), 32'd0);

    // Release with en held high; this cycle is cycle 0
    en = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Sample in WARM: dither ignored, -1 truncates to -1
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(17'h1FFFF, 3'd7, 5'h1F, 1'b0);

    // Wait for RUN
    while (cyc < 47) begin
      @(posedge clk);
      #1;
    end

    // Rounding and saturation in RUN
    applyStimulus(17'd2048, 3'd0, 5'd0, 1'b0);
    applyStimulus(17'd2048, 3'd7, 5'd1, 1'b0);
    applyStimulus(17'd4000, 3'd1, 5'd1, 1'b0);
    applyStimulus(17'd65535, 3'd7, 5'h0F, 1'b1);
    applyStimulus(17'h10000, 3'd0, 5'h10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("sat_count_first", 32'(sat_count), 32'(CNT_ONE));

    // Clear coincident with a saturated output wins
    applyStimulus(17'd65535, 3'd7, 5'h0F, 1'b1);
    @(posedge clk);
    #1;
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat_count_after_clear", 32'(sat_count), 32'd0);
    applyStimulus(17'd65535, 3'd7, 5'h0F, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("sat_count_after_resat", 32'(sat_count), 32'(CNT_ONE));

    // en drop with two samples in flight: both dithered, next truncated
    applyStimulus(17'd4000, 3'd1, 5'd1, 1'b0);
    applyStimulus(17'd4000, 3'd1, 5'd1, 1'b0);
    en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("en_drop_lfsr_rst", 32'(lfsr_rst), 32'd1);
    checkOutput("en_drop_dither_on", 32'(dither_on), 32'd0);
    applyStimulus(17'd4000, 3'd1, 5'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Back to RUN, then assert reset while an output is valid
    en = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("rerun_dither_on", 32'(dither_on), 32'd1);
    applyStimulus(17'd2048, 3'd7, 5'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_out_valid", 32'(bus.out_valid_o), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("async_reset_lfsr_rst", 32'(lfsr_rst), 32'd1);
    checkOutput("async_reset_dither_on", 32'(dither_on), 32'd0);
    #20;

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
